// File: rtl/gate_tester_pkg.sv
// Shared gate-function codes and checker state encoding for the IC tester gate checkers.
package gate_tester_pkg;
  localparam int GT_W = 3;

  localparam logic [GT_W-1:0] GT_NOT  = 3'd0;
  localparam logic [GT_W-1:0] GT_AND  = 3'd1;
  localparam logic [GT_W-1:0] GT_OR   = 3'd2;
  localparam logic [GT_W-1:0] GT_NAND = 3'd3;
  localparam logic [GT_W-1:0] GT_NOR  = 3'd4;
  localparam logic [GT_W-1:0] GT_XOR  = 3'd5;
  localparam logic [GT_W-1:0] GT_XNOR = 3'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/gate_ref_model.sv
// Golden gate function: expected output of one ideal gate for a given input pattern.
module gate_ref_model
  import gate_tester_pkg::*;
#(
  parameter int N_INPUTS = 2
) (
  input  logic [GT_W-1:0]     gate_type,
  input  logic [N_INPUTS-1:0] pattern,
  output logic                expected,
  output logic                valid
);
  // An inverter only makes sense on single-input parts; everything else needs two or more.
  localparam bit MULTI = (N_INPUTS >= 2);

  always_comb begin
    expected = 1'b0;
    valid    = 1'b0;
    case (gate_type)
      GT_NOT:  begin valid = ~MULTI; expected = ~pattern[0]; end
      GT_AND:  begin valid = MULTI;  expected = &pattern;    end
      GT_OR:   begin valid = MULTI;  expected = |pattern;    end
      GT_NAND: begin valid = MULTI;  expected = ~&pattern;   end
      GT_NOR:  begin valid = MULTI;  expected = ~|pattern;   end
      GT_XOR:  begin valid = MULTI;  expected = ^pattern;    end
      GT_XNOR: begin valid = MULTI;  expected = ~^pattern;   end
      default: ;
    endcase
  end
endmodule

// File: rtl/gate_array_checker.sv
// Exhaustive tester for N_GATES identical gates: sweeps every input pattern,
// waits SETTLE_CYCLES per pattern, and reports sticky per-gate mismatches.
module gate_array_checker
  import gate_tester_pkg::*;
#(
  parameter int N_GATES       = 4,
  parameter int N_INPUTS      = 2,
  parameter int SETTLE_CYCLES = 50000000,
  parameter int CNT_W         = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          start,
  input  logic [2:0]                    gate_type,
  input  logic [N_GATES-1:0]            op,
  output logic [N_GATES*N_INPUTS-1:0]   stim,
  output logic                          busy,
  output logic                          done,
  output logic [N_GATES-1:0]            pass_vec,
  output logic [N_GATES-1:0]            fail_vec,
  output logic                          pass,
  output logic                          fail
);
  localparam int                  SW       = N_GATES * N_INPUTS;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] PAT_LAST = '1;

  state_t                state_q, state_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic [N_INPUTS-1:0]   pat_q, pat_nxt;
  logic [N_GATES-1:0]    mis_q, mis_nxt, smp_mis;
  logic [GT_W-1:0]       gt_q, gt_nxt, ref_type;
  logic                  exp_bit, ref_valid;

  logic [SW-1:0]         stim_nxt;
  logic                  busy_nxt, done_nxt, pass_nxt, fail_nxt;
  logic [N_GATES-1:0]    pv_nxt, fv_nxt;

  // In IDLE the incoming code is qualified before it is latched.
  assign ref_type = (state_q == IDLE) ? gate_type : gt_q;

  gate_ref_model #(.N_INPUTS(N_INPUTS)) u_ref (
    .gate_type (ref_type),
    .pattern   (pat_q),
    .expected  (exp_bit),
    .valid     (ref_valid)
  );

  // 4-state compare so a floating or unknown DUT pin is a mismatch.
  for (genvar g = 0; g < N_GATES; g++) begin : g_cmp
    assign smp_mis[g] = (op[g] !== exp_bit);
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    pat_nxt   = pat_q;
    mis_nxt   = mis_q;
    gt_nxt    = gt_q;
    stim_nxt  = stim;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    pv_nxt    = pass_vec;
    fv_nxt    = fail_vec;
    pass_nxt  = pass;
    fail_nxt  = fail;

    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      pat_nxt   = '0;
      mis_nxt   = '0;
      stim_nxt  = '0;
      busy_nxt  = 1'b0;
      pv_nxt    = '0;
      fv_nxt    = '0;
      pass_nxt  = 1'b0;
      fail_nxt  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          gt_nxt   = gate_type;
          cnt_nxt  = '0;
          pat_nxt  = '0;
          stim_nxt = '0;
          if (ref_valid) begin
            mis_nxt   = '0;
            busy_nxt  = 1'b1;
            state_nxt = SETTLE;
            pv_nxt    = '0;
            fv_nxt    = '0;
            pass_nxt  = 1'b0;
            fail_nxt  = 1'b0;
          end else begin
            mis_nxt   = '1;
            state_nxt = DONE;
            done_nxt  = 1'b1;
            pv_nxt    = '0;
            fv_nxt    = '1;
            pass_nxt  = 1'b0;
            fail_nxt  = 1'b1;
          end
        end
        SETTLE: begin
          cnt_nxt = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_nxt = SAMPLE;
        end
        SAMPLE: begin
          mis_nxt = mis_q | smp_mis;
          if (pat_q == PAT_LAST) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            stim_nxt  = '0;
            pv_nxt    = ~mis_nxt;
            fv_nxt    = mis_nxt;
            pass_nxt  = ~|mis_nxt;
            fail_nxt  = |mis_nxt;
          end else begin
            pat_nxt   = pat_q + N_INPUTS'(1);
            cnt_nxt   = '0;
            stim_nxt  = {N_GATES{pat_nxt}};
            state_nxt = SETTLE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pat_q    <= '0;
      mis_q    <= '0;
      gt_q     <= '0;
      stim     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass_vec <= '0;
      fail_vec <= '0;
      pass     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      pat_q    <= pat_nxt;
      mis_q    <= mis_nxt;
      gt_q     <= gt_nxt;
      stim     <= stim_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      pass_vec <= pv_nxt;
      fail_vec <= fv_nxt;
      pass     <= pass_nxt;
      fail     <= fail_nxt;
    end
  end
endmodule
